// File: rtl/alu_driver_if.sv
// Command, ALU and response signals of alu_driver, grouped for port connection.
// The master modport is the driver's view; slave is the environment (source, ALU, sink).
interface alu_driver_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic       alu_en_i;
    logic       alu_en_o;
    logic [1:0] alu_select_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_err;
    logic [7:0] cmd_cnt;
    logic [7:0] err_cnt;

    modport master (
        input  req_valid, req_op, req_a, req_b, alu_out, rsp_ready,
        output req_ready, alu_en_i, alu_en_o, alu_select_op, alu_a, alu_b,
        output rsp_valid, rsp_data, rsp_err, cmd_cnt, err_cnt
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, alu_out, rsp_ready,
        input  req_ready, alu_en_i, alu_en_o, alu_select_op, alu_a, alu_b,
        input  rsp_valid, rsp_data, rsp_err, cmd_cnt, err_cnt
    );
endinterface

// File: rtl/alu_driver.sv
// Sequences one command at a time through a registered ALU, checks each result against
// a golden model and queues results in a 2-entry in-order response buffer.
module alu_driver #(
    parameter bit CHECK_EN = 1'b1
) (
    input logic          clk,
    input logic          rst,
    alu_driver_if.master bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StExec, StCapt} state_e;

    state_e     state_q, state_d;
    logic [1:0] op_q;
    logic [3:0] a_q, b_q;
    logic       started_q;
    logic [4:0] fifo_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] count_q;
    logic [7:0] cmd_cnt_q, err_cnt_q;
    logic       accept, push, pop, err;
    logic [3:0] golden;

    // started_q keeps req_ready low until the first edge after reset release.
    assign bus.req_ready = started_q && (state_q == StIdle) && (count_q < 2'd2);
    assign accept        = bus.req_valid && bus.req_ready;
    assign push          = (state_q == StCapt);
    assign bus.rsp_valid = (count_q != 2'd0);
    assign pop           = bus.rsp_valid && bus.rsp_ready;

    assign bus.rsp_data      = bus.rsp_valid ? fifo_q[rd_ptr_q][3:0] : 4'h0;
    assign bus.rsp_err       = bus.rsp_valid ? fifo_q[rd_ptr_q][4] : 1'b0;
    assign bus.alu_select_op = op_q;
    assign bus.cmd_cnt       = cmd_cnt_q;
    assign bus.err_cnt       = err_cnt_q;

    always_comb begin
        golden = 4'h0;
        case (op_q)
            2'b00:   golden = a_q + b_q;
            2'b01:   golden = a_q & b_q;
            2'b10:   golden = a_q | b_q;
            default: golden = ~(a_q & b_q);
        endcase
        err = CHECK_EN && (bus.alu_out != golden);
    end

    always_comb begin
        state_d      = state_q;
        bus.alu_en_i = 1'b0;
        bus.alu_en_o = 1'b0;
        bus.alu_a    = 4'h0;
        bus.alu_b    = 4'h0;
        unique case (state_q)
            StIdle: if (accept) state_d = StLoad;
            StLoad: begin
                bus.alu_en_i = 1'b1;
                bus.alu_a    = a_q;
                bus.alu_b    = b_q;
                state_d      = StExec;
            end
            StExec: begin
                bus.alu_en_o = 1'b1;
                state_d      = StCapt;
            end
            StCapt: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            started_q <= 1'b0;
            op_q      <= 2'b00;
            a_q       <= 4'h0;
            b_q       <= 4'h0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            if (accept) begin
                op_q <= bus.req_op;
                a_q  <= bus.req_a;
                b_q  <= bus.req_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q[0] <= 5'h0;
            fifo_q[1] <= 5'h0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {err, bus.alu_out};
                wr_ptr_q         <= !wr_ptr_q;
            end
            if (pop) rd_ptr_q <= !rd_ptr_q;
            if (push && !pop)      count_q <= count_q + 2'd1;
            else if (pop && !push) count_q <= count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_cnt_q <= 8'd0;
            err_cnt_q <= 8'd0;
        end else if (push) begin
            if (cmd_cnt_q != 8'hff)        cmd_cnt_q <= cmd_cnt_q + 8'd1;
            if (err && err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver: a checking instance and a CHECK_EN=0 instance share stimulus,
// each paired with a behavioural registered ALU that can be forced to a wrong result.
module tb_alu_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'b00;
    logic [3:0] req_a = 4'h0, req_b = 4'h0;
    logic       rsp_ready = 1'b0;
    logic       fault = 1'b0;
    int n_cmp = 0, n_err = 0;
    int en_i_cnt = 0, en_o_cnt = 0, acc_cnt = 0;
    logic [3:0] ma0 = 4'h0, mb0 = 4'h0, out0 = 4'h0;
    logic [3:0] ma1 = 4'h0, mb1 = 4'h0, out1 = 4'h0;

    always #5 clk = ~clk;

    alu_driver_if bus0();
    alu_driver_if bus1();

    alu_driver #(.CHECK_EN(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    alu_driver #(.CHECK_EN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus0.req_valid = req_valid;
    assign bus0.req_op    = req_op;
    assign bus0.req_a     = req_a;
    assign bus0.req_b     = req_b;
    assign bus0.rsp_ready = rsp_ready;
    assign bus0.alu_out   = out0;
    assign bus1.req_valid = req_valid;
    assign bus1.req_op    = req_op;
    assign bus1.req_a     = req_a;
    assign bus1.req_b     = req_b;
    assign bus1.rsp_ready = rsp_ready;
    assign bus1.alu_out   = out1;

    function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return ~(a & b);
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus0.alu_en_i) begin ma0 <= bus0.alu_a; mb0 <= bus0.alu_b; end
        if (bus0.alu_en_o) out0 <= fault ? 4'h3 : alu_f(bus0.alu_select_op, ma0, mb0);
        if (bus1.alu_en_i) begin ma1 <= bus1.alu_a; mb1 <= bus1.alu_b; end
        if (bus1.alu_en_o) out1 <= fault ? 4'h3 : alu_f(bus1.alu_select_op, ma1, mb1);
        if (bus0.alu_en_i) en_i_cnt <= en_i_cnt + 1;
        if (bus0.alu_en_o) en_o_cnt <= en_o_cnt + 1;
        if (bus0.req_valid && bus0.req_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one tick after the handshake edge, i.e. with the DUT in LOAD.
    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        for (int i = 0; i < 50 && !bus0.req_ready; i++) tick();
        if (!bus0.req_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: req_ready got 0 want 1");
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic pop_one();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({bus0.req_ready, bus0.rsp_valid, bus0.alu_en_i, bus0.alu_en_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 0000",
                     {bus0.req_ready, bus0.rsp_valid, bus0.alu_en_i, bus0.alu_en_o});
        end
        n_cmp++;
        if ({bus0.cmd_cnt, bus0.err_cnt, bus0.rsp_data} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", {bus0.cmd_cnt, bus0.err_cnt, bus0.rsp_data});
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus0.req_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_release_ready: got %b want 0", bus0.req_ready);
        end
        tick();
        n_cmp++;
        if (bus0.req_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_first_edge_ready: got %b want 1", bus0.req_ready);
        end
    endtask

    task automatic test_add();
        send(2'b00, 4'h9, 4'h8);
        n_cmp++;
        if ({bus0.alu_en_i, bus0.alu_en_o, bus0.alu_a, bus0.alu_b} !== 10'b10_1001_1000) begin
            n_err++; $display("FAIL add_load: got %b want 1010011000",
                              {bus0.alu_en_i, bus0.alu_en_o, bus0.alu_a, bus0.alu_b});
        end
        tick();
        n_cmp++;
        if ({bus0.alu_en_i, bus0.alu_en_o, bus0.alu_a} !== 6'b01_0000) begin
            n_err++; $display("FAIL add_exec: got %b want 010000",
                              {bus0.alu_en_i, bus0.alu_en_o, bus0.alu_a});
        end
        tick();
        n_cmp++;
        if (bus0.rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL add_early_valid: got %b want 0", bus0.rsp_valid);
        end
        tick();
        n_cmp++;
        if ({bus0.rsp_valid, bus0.rsp_data, bus0.rsp_err, bus0.cmd_cnt} !== {1'b1, 4'h1, 1'b0, 8'd1})
        begin
            n_err++; $display("FAIL add_result: got v%b d%h e%b c%0d want v1 d1 e0 c1",
                              bus0.rsp_valid, bus0.rsp_data, bus0.rsp_err, bus0.cmd_cnt);
        end
        pop_one();
        n_cmp++;
        if ({bus0.rsp_valid, bus0.rsp_data} !== 5'h0) begin
            n_err++; $display("FAIL add_pop_empty: got %b want 00000",
                              {bus0.rsp_valid, bus0.rsp_data});
        end
    endtask

    task automatic test_in_order();
        int ei, eo;
        ei = en_i_cnt; eo = en_o_cnt;
        send(2'b11, 4'hf, 4'hf);
        send(2'b10, 4'h5, 4'ha);
        tick(); tick(); tick();
        n_cmp++;
        if ((en_i_cnt - ei) != 2 || (en_o_cnt - eo) != 2) begin
            n_err++; $display("FAIL order_enables: got %0d/%0d want 2/2",
                              en_i_cnt - ei, en_o_cnt - eo);
        end
        n_cmp++;
        if ({bus0.rsp_valid, bus0.rsp_data} !== {1'b1, 4'h0}) begin
            n_err++; $display("FAIL order_first: got v%b d%h want v1 d0",
                              bus0.rsp_valid, bus0.rsp_data);
        end
        pop_one();
        n_cmp++;
        if ({bus0.rsp_valid, bus0.rsp_data} !== {1'b1, 4'hf}) begin
            n_err++; $display("FAIL order_second: got v%b d%h want v1 df",
                              bus0.rsp_valid, bus0.rsp_data);
        end
        pop_one();
        n_cmp++;
        if (bus0.rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL order_drained: got %b want 0", bus0.rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int acc, cmd;
        acc = acc_cnt; cmd = int'(bus0.cmd_cnt);
        req_valid = 1'b1; req_op = 2'b00; req_a = 4'h1; req_b = 4'h1;
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if ((acc_cnt - acc) != 2 || bus0.req_ready !== 1'b0 || (int'(bus0.cmd_cnt) - cmd) != 2)
        begin
            n_err++; $display("FAIL bp_full: got acc %0d rdy %b cmd %0d want 2 0 2",
                              acc_cnt - acc, bus0.req_ready, int'(bus0.cmd_cnt) - cmd);
        end
        pop_one();
        for (int i = 0; i < 8; i++) tick();
        req_valid = 1'b0;
        n_cmp++;
        if ((acc_cnt - acc) != 3 || bus0.req_ready !== 1'b0 || bus0.rsp_data !== 4'h2) begin
            n_err++; $display("FAIL bp_third: got acc %0d rdy %b d%h want 3 0 d2",
                              acc_cnt - acc, bus0.req_ready, bus0.rsp_data);
        end
        pop_one();
        pop_one();
        n_cmp++;
        if (bus0.rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_drained: got %b want 0", bus0.rsp_valid);
        end
    endtask

    task automatic test_fault();
        fault = 1'b1;
        send(2'b01, 4'hc, 4'ha);
        tick(); tick(); tick();
        n_cmp++;
        if ({bus0.rsp_valid, bus0.rsp_data, bus0.rsp_err, bus0.err_cnt} !== {1'b1, 4'h3, 1'b1, 8'd1})
        begin
            n_err++; $display("FAIL fault_check_on: got v%b d%h e%b ec%0d want v1 d3 e1 ec1",
                              bus0.rsp_valid, bus0.rsp_data, bus0.rsp_err, bus0.err_cnt);
        end
        n_cmp++;
        if ({bus1.rsp_valid, bus1.rsp_err, bus1.err_cnt} !== {1'b1, 1'b0, 8'd0}) begin
            n_err++; $display("FAIL fault_check_off: got v%b e%b ec%0d want v1 e0 ec0",
                              bus1.rsp_valid, bus1.rsp_err, bus1.err_cnt);
        end
        pop_one();
        fault = 1'b0;
        n_cmp++;
        if (bus0.rsp_err !== 1'b0) begin
            n_err++; $display("FAIL fault_err_empty: got %b want 0", bus0.rsp_err);
        end
    endtask

    task automatic test_reset_mid();
        send(2'b00, 4'h2, 4'h2);
        tick();
        n_cmp++;
        if (bus0.alu_en_o !== 1'b1) begin
            n_err++; $display("FAIL mid_in_exec: got %b want 1", bus0.alu_en_o);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus0.alu_en_i, bus0.alu_en_o, bus0.req_ready} !== 3'b000) begin
            n_err++; $display("FAIL mid_rst_immediate: got %b want 000",
                              {bus0.alu_en_i, bus0.alu_en_o, bus0.req_ready});
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_cmp++;
        if ({bus0.rsp_valid, bus0.cmd_cnt} !== 9'h0) begin
            n_err++; $display("FAIL mid_no_response: got v%b c%0d want v0 c0",
                              bus0.rsp_valid, bus0.cmd_cnt);
        end
        send(2'b00, 4'h3, 4'h4);
        tick(); tick(); tick();
        n_cmp++;
        if ({bus0.rsp_valid, bus0.rsp_data, bus0.rsp_err, bus0.cmd_cnt} !== {1'b1, 4'h7, 1'b0, 8'd1})
        begin
            n_err++; $display("FAIL mid_next_cmd: got v%b d%h e%b c%0d want v1 d7 e0 c1",
                              bus0.rsp_valid, bus0.rsp_data, bus0.rsp_err, bus0.cmd_cnt);
        end
        pop_one();
    endtask

    task automatic test_saturate();
        fault = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_op = 2'b01; req_a = 4'hc; req_b = 4'ha;
        for (int i = 0; i < 260 * 4 + 20; i++) tick();
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rsp_ready = 1'b0;
        fault = 1'b0;
        n_cmp++;
        if (bus0.err_cnt !== 8'd255 || bus0.cmd_cnt !== 8'd255) begin
            n_err++; $display("FAIL sat_counts: got ec%0d c%0d want 255 255",
                              bus0.err_cnt, bus0.cmd_cnt);
        end
        n_cmp++;
        if (bus1.err_cnt !== 8'd0) begin
            n_err++; $display("FAIL sat_check_off: got ec%0d want 0", bus1.err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_in_order();
        test_back_to_back();
        test_fault();
        test_reset_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
